// File: rtl/pifo_reg_drain.sv
// Dequeue stage behind the PIFO register: pops the min entry (optionally time-gated) into a 4-deep FWFT FIFO.
// Pop-to-output latency 1 cycle; pops stall while the FIFO is full and m_ready is low.

module pifo_fifo #(
  parameter int W   = 28,
  parameter int L2D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic         o_vld,
  output logic [W-1:0] o_dat,
  output logic [L2D:0] o_cnt
);
  localparam logic [L2D:0] DEPTH = (L2D+1)'(1 << L2D);

  logic [W-1:0]   r_mem [1 << L2D];
  logic [L2D-1:0] r_wr;
  logic [L2D-1:0] r_rd;
  logic [L2D:0]   r_cnt;
  logic           w_push;
  logic           w_pop;

  assign w_pop  = i_pop & (r_cnt != '0);
  // A same-cycle read frees the slot, so a full FIFO may still accept.
  assign w_push = i_push & ((r_cnt != DEPTH) | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_push_dat;
  end

  assign o_vld = (r_cnt != '0);
  assign o_dat = o_vld ? r_mem[r_rd] : '0;
  assign o_cnt = r_cnt;
endmodule

module pifo_reg_drain #(
  parameter int RANK_WIDTH   = 16,
  parameter int META_WIDTH   = 12,
  parameter int L2_OUT_DEPTH = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    gate_en,
  input  logic [RANK_WIDTH-1:0]   now,
  input  logic                    pifo_valid,
  input  logic [RANK_WIDTH-1:0]   pifo_rank,
  input  logic [META_WIDTH-1:0]   pifo_meta,
  output logic                    pifo_remove,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [RANK_WIDTH-1:0]   m_rank,
  output logic [META_WIDTH-1:0]   m_meta,
  output logic [L2_OUT_DEPTH:0]   fifo_count,
  output logic [CNT_WIDTH-1:0]    pop_count,
  output logic [CNT_WIDTH-1:0]    gated_cycles
);
  localparam logic [L2_OUT_DEPTH:0] OUT_DEPTH = (L2_OUT_DEPTH+1)'(1 << L2_OUT_DEPTH);
  localparam int EW = RANK_WIDTH + META_WIDTH;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t         r_state;
  state_t         w_next;
  logic           w_room;
  logic           w_eligible;
  logic           w_ready_to_pop;
  logic           w_gated;
  logic [EW-1:0]  w_head;

  assign w_room         = (fifo_count < OUT_DEPTH) | (m_valid & m_ready);
  assign w_eligible     = ~gate_en | (pifo_rank <= now);
  assign w_ready_to_pop = ~rst & en & pifo_valid & w_room;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // HOLD masks the register's stale min outputs while it recomputes.
  always_comb begin
    w_next      = r_state;
    pifo_remove = 1'b0;
    w_gated     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ready_to_pop & w_eligible) begin
          pifo_remove = 1'b1;
          w_next      = HOLD;
        end
        w_gated = w_ready_to_pop & ~w_eligible;
      end
      HOLD: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  pifo_fifo #(
    .W   (EW),
    .L2D (L2_OUT_DEPTH)
  ) u_out_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (pifo_remove),
    .i_push_dat ({pifo_rank, pifo_meta}),
    .i_pop      (m_ready),
    .o_vld      (m_valid),
    .o_dat      (w_head),
    .o_cnt      (fifo_count)
  );

  assign m_rank = w_head[EW-1:META_WIDTH];
  assign m_meta = w_head[META_WIDTH-1:0];

  // Statistics counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_count    <= '0;
      gated_cycles <= '0;
    end else begin
      if (pifo_remove & (pop_count != '1))  pop_count    <= pop_count + 1'b1;
      if (w_gated & (gated_cycles != '1))   gated_cycles <= gated_cycles + 1'b1;
    end
  end
endmodule
